// File: rtl/gf_symbol_bank_buf.sv
// Serial-bit to GF(2^SYM_W) symbol packer with NBANK round-robin frame banks
// and a valid/ready symbol stream toward the NB-LDPC encoder.
module gf_symbol_bank_buf #(
    parameter int SYM_W      = 6,
    parameter int FRAME_SYMS = 49,
    parameter int NBANK      = 2,
    parameter int ADDR_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             abort,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [2:0]       bank_cnt,
    output logic             empty,
    output logic             full,
    output logic [1:0]       dbg_rd_state
);

    // Handshake: a transfer happens on a rising edge where en is high and both
    // valid and ready are high; out_sym/out_valid hold while stalled.
    localparam int BANK_W = (NBANK > 2) ? 2 : 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SYMS - 1);
    localparam logic [SYM_W-1:0]  POS_MSB   = {1'b1, {(SYM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_OUT   = 2'd2
    } rd_state_t;

    logic [SYM_W-1:0]  r_mem [NBANK][DEPTH];
    logic [NBANK-1:0]  r_occ;
    logic [BANK_W-1:0] r_wr_bank;
    logic [BANK_W-1:0] r_rd_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [SYM_W-1:0]  r_shift;
    logic [SYM_W-1:0]  r_pos;
    logic [SYM_W-1:0]  r_out_sym;
    logic              r_out_valid;
    logic [2:0]        r_bank_cnt;
    logic              r_empty;
    logic              r_full;
    rd_state_t         r_state;

    logic              w_accept;
    logic              w_sym_done;
    logic              w_frame_done;
    logic [SYM_W-1:0]  w_sym;
    rd_state_t         w_state_nxt;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_release;
    logic [NBANK-1:0]  w_occ_nxt;
    logic [2:0]        w_cnt_nxt;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NBANK - 1)) ? '0 : b + 1'b1;
    endfunction

    assign in_ready     = en & ~r_occ[r_wr_bank] & ~abort;
    assign w_accept     = in_valid & in_ready;
    // Current bit dropped into the one-hot slot; on the last slot this is the full symbol.
    assign w_sym        = (r_shift & ~r_pos) | (r_pos & {SYM_W{in_bit}});
    assign w_sym_done   = w_accept & r_pos[0];
    assign w_frame_done = w_sym_done & (r_wr_addr == LAST_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_addr = r_rd_addr;
        w_release   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_occ[r_rd_bank]) w_state_nxt = R_FETCH;
            end
            R_FETCH: begin
                w_load      = 1'b1;
                w_state_nxt = R_OUT;
            end
            R_OUT: begin
                if (out_ready) begin
                    if (r_rd_addr == LAST_ADDR) begin
                        w_release   = 1'b1;
                        w_state_nxt = R_IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_load_addr = r_rd_addr + 1'b1;
                    end
                end
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    // Completion and release on different banks may coincide; both apply.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_frame_done) w_occ_nxt[r_wr_bank] = 1'b1;
        if (w_release)    w_occ_nxt[r_rd_bank] = 1'b0;
        w_cnt_nxt = '0;
        for (int i = 0; i < NBANK; i++) w_cnt_nxt = w_cnt_nxt + {2'b00, w_occ_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else if (en) r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_sym_done) r_mem[r_wr_bank][r_wr_addr] <= w_sym;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ       <= '0;
            r_wr_bank   <= '0;
            r_rd_bank   <= '0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_shift     <= '0;
            r_pos       <= POS_MSB;
            r_out_sym   <= '0;
            r_out_valid <= 1'b0;
            r_bank_cnt  <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
        end else if (en) begin
            r_occ      <= w_occ_nxt;
            r_bank_cnt <= w_cnt_nxt;
            r_empty    <= (w_cnt_nxt == 3'd0);
            r_full     <= (w_cnt_nxt == 3'(NBANK));
            if (abort) begin
                r_wr_addr <= '0;
                r_shift   <= '0;
                r_pos     <= POS_MSB;
            end else if (w_accept) begin
                if (r_pos[0]) begin
                    r_shift <= '0;
                    r_pos   <= POS_MSB;
                    if (w_frame_done) begin
                        r_wr_addr <= '0;
                        r_wr_bank <= next_bank(r_wr_bank);
                    end else begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end
                end else begin
                    r_shift <= w_sym;
                    r_pos   <= r_pos >> 1;
                end
            end
            if (w_load) begin
                r_out_sym   <= r_mem[r_rd_bank][w_load_addr];
                r_out_valid <= 1'b1;
                r_rd_addr   <= w_load_addr;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_rd_addr   <= '0;
                r_rd_bank   <= next_bank(r_rd_bank);
            end
        end
    end

    assign out_sym      = r_out_sym;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_valid & (r_rd_addr == LAST_ADDR);
    assign bank_cnt     = r_bank_cnt;
    assign empty        = r_empty;
    assign full         = r_full;
    assign dbg_rd_state = r_state;

endmodule

// File: tb/tb_gf_symbol_bank_buf.sv
// Bench for gf_symbol_bank_buf: default instance plus a SYM_W=4/FRAME_SYMS=8/NBANK=3
// instance, each checked by a frame-level reference model and an expected-symbol queue.
module tb_gf_symbol_bank_buf;
    localparam int SW = 6, FS = 49, NB = 2, AW = 6;
    localparam int PSW = 4, PFS = 8, PNB = 3, PAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, abort, in_bit, in_valid, out_ready;
    logic in_ready, out_valid, out_last, empty, full;
    logic [SW-1:0] out_sym;
    logic [2:0] bank_cnt;
    logic [1:0] dbg_state;

    logic p_abort, p_in_bit, p_in_valid, p_out_ready;
    logic p_in_ready, p_out_valid, p_out_last, p_empty, p_full;
    logic [PSW-1:0] p_out_sym;
    logic [2:0] p_bank_cnt;
    logic [1:0] p_dbg_state;

    gf_symbol_bank_buf #(.SYM_W(SW), .FRAME_SYMS(FS), .NBANK(NB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .abort(abort), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .bank_cnt(bank_cnt), .empty(empty), .full(full),
        .dbg_rd_state(dbg_state));

    gf_symbol_bank_buf #(.SYM_W(PSW), .FRAME_SYMS(PFS), .NBANK(PNB), .ADDR_W(PAW)) dut_p (
        .clk(clk), .rst(rst), .en(en), .abort(p_abort), .in_bit(p_in_bit), .in_valid(p_in_valid),
        .in_ready(p_in_ready), .out_sym(p_out_sym), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_last(p_out_last), .bank_cnt(p_bank_cnt), .empty(p_empty), .full(p_full),
        .dbg_rd_state(p_dbg_state));

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: default instance ----------------
    logic [SW:0]   exp_q[$];   // {last, symbol}
    logic [SW-1:0] pend_q[$];
    logic [SW-1:0] cur_sym = '0;
    int cur_n = 0;
    int n_acc = 0;

    function automatic void model_bit(input logic b);
        cur_sym = {cur_sym[SW-2:0], b};
        cur_n++;
        if (cur_n == SW) begin
            pend_q.push_back(cur_sym);
            cur_n = 0;
            cur_sym = '0;
            if (pend_q.size() == FS) begin
                foreach (pend_q[k]) exp_q.push_back({(k == FS - 1), pend_q[k]});
                pend_q.delete();
            end
        end
    endfunction

    function automatic void model_clear();
        pend_q.delete();
        cur_n = 0;
        cur_sym = '0;
    endfunction

    // ---------------- reference model: parametrised instance ----------------
    logic [PSW:0]   p_exp_q[$];
    logic [PSW-1:0] p_pend_q[$];
    logic [PSW-1:0] p_cur_sym = '0;
    int p_cur_n = 0;

    function automatic void p_model_bit(input logic b);
        p_cur_sym = {p_cur_sym[PSW-2:0], b};
        p_cur_n++;
        if (p_cur_n == PSW) begin
            p_pend_q.push_back(p_cur_sym);
            p_cur_n = 0;
            p_cur_sym = '0;
            if (p_pend_q.size() == PFS) begin
                foreach (p_pend_q[k]) p_exp_q.push_back({(k == PFS - 1), p_pend_q[k]});
                p_pend_q.delete();
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        int w;
        in_bit = b;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_bit(b);
        n_acc++;
        #1;
    endtask

    task automatic send_rand(input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        in_valid = 1'b0;
    endtask

    task automatic p_send_bit(input logic b);
        int w;
        p_in_bit = b;
        p_in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!p_in_ready && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (!p_in_ready) begin
            chk("p_in_ready_timeout", 0, 1);
            p_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        p_model_bit(b);
        #1;
    endtask

    task automatic wait_drain();
        int w = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && empty && !out_valid) && w < 3000) begin
            w++;
            @(negedge clk);
        end
        chk("drain_pending_symbols", exp_q.size(), 0);
        chk("drain_empty", empty, 1);
    endtask

    // ---------------- monitors / scoreboards ----------------
    int mon_cnt = 0;
    int mon_2c = 0;
    int peak = 0;
    logic prev_stall = 1'b0;
    logic [SW-1:0] prev_sym = '0;

    always @(negedge clk) begin
        logic [SW:0] e;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_sym_hold", out_sym, prev_sym);
            end
            if (int'(bank_cnt) > peak) peak = bank_cnt;
            chk("empty_vs_cnt", empty, (bank_cnt == 0) ? 1 : 0);
            chk("full_vs_cnt", full, (bank_cnt == NB) ? 1 : 0);
            if (!out_valid) chk("last_without_valid", out_last, 0);
            if (out_valid && out_ready && en) begin
                chk("exp_q_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_sym", out_sym, e[SW-1:0]);
                    chk("out_last", out_last, e[SW]);
                end
                mon_cnt++;
                if (out_sym == 6'h2C) mon_2c++;
            end
            prev_stall = out_valid && !(out_ready && en);
            prev_sym = out_sym;
        end
    end

    int p_peak = 0;
    logic p_prev_stall = 1'b0;
    logic [PSW-1:0] p_prev_sym = '0;

    always @(negedge clk) begin
        logic [PSW:0] e;
        if (!rst) begin
            p_prev_stall = 1'b0;
        end else begin
            if (p_prev_stall) begin
                chk("p_stall_valid_hold", p_out_valid, 1);
                chk("p_stall_sym_hold", p_out_sym, p_prev_sym);
            end
            if (int'(p_bank_cnt) > p_peak) p_peak = p_bank_cnt;
            if (p_out_valid && p_out_ready && en) begin
                chk("p_exp_q_nonempty", (p_exp_q.size() != 0) ? 1 : 0, 1);
                if (p_exp_q.size() != 0) begin
                    e = p_exp_q.pop_front();
                    chk("p_out_sym", p_out_sym, e[PSW-1:0]);
                    chk("p_out_last", p_out_last, e[PSW]);
                end
            end
            p_prev_stall = p_out_valid && !(p_out_ready && en);
            p_prev_sym = p_out_sym;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int w;
        int target;
        logic p_done;
        rst = 1'b0; en = 1'b0; abort = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        p_abort = 1'b0; p_in_bit = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sym", out_sym, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_bank_cnt", bank_cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready_en0", in_ready, 0);
        chk("rst_p_empty", p_empty, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        // single frame with the fixed pattern, then latency
        @(posedge clk); #1;
        out_ready = 1'b1;
        mon_2c = 0;
        for (int i = 0; i < FS * SW; i++) send_bit(pat[i % 6]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_bank_cnt_1", bank_cnt, 1);
        chk("lat_cycle0_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        wait_drain();
        chk("pattern_2c_count", mon_2c, FS);

        // backpressure fill
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_rand(2 * FS * SW);
        @(negedge clk);
        chk("bp_full", full, 1);
        chk("bp_bank_cnt", bank_cnt, 2);
        in_bit = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!(out_valid && out_last) && w < 500) begin
            w++;
            @(negedge clk);
        end
        chk("bp_frame0_last_seen", (out_valid && out_last) ? 1 : 0, 1);
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_bank_cnt_after_release", bank_cnt, 1);
        @(posedge clk); #1;
        send_rand(FS * SW);
        wait_drain();

        // abort a partial frame
        @(posedge clk); #1;
        peak = 0;
        mon_cnt = 0;
        send_rand(100);
        abort = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("abort_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        abort = 1'b0;
        send_rand(FS * SW);
        wait_drain();
        chk("abort_sym_count", mon_cnt, FS);
        chk("abort_peak_cnt", peak, 1);

        // enable freeze mid-symbol and mid-read
        @(posedge clk); #1;
        mon_cnt = 0;
        target = n_acc + FS * SW + 9;
        fork
            send_rand(2 * FS * SW);
            begin
                w = 0;
                while (n_acc < target && w < 3000) begin
                    w++;
                    @(negedge clk);
                end
                @(posedge clk); #1;
                en = 1'b0;
                @(negedge clk);
                chk("freeze_mid_read", out_valid, 1);
                repeat (10) @(posedge clk);
                #1;
                en = 1'b1;
            end
        join
        wait_drain();
        chk("freeze_sym_count", mon_cnt, 2 * FS);

        // async reset during a read
        @(posedge clk); #1;
        send_rand(FS * SW);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sym", out_sym, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_bank_cnt", bank_cnt, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        model_clear();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        mon_cnt = 0;
        send_rand(FS * SW);
        wait_drain();
        chk("post_reset_sym_count", mon_cnt, FS);

        // parametrised instance, random out_ready
        @(posedge clk); #1;
        p_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12 * PFS * PSW; i++) p_send_bit(1'($urandom_range(0, 1)));
                p_in_valid = 1'b0;
                p_done = 1'b1;
            end
            begin
                while (!p_done) begin
                    @(posedge clk); #1;
                    p_out_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        p_out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!(p_exp_q.size() == 0 && p_empty && !p_out_valid) && w < 2000) begin
            w++;
            @(negedge clk);
        end
        chk("p_drain_pending", p_exp_q.size(), 0);
        chk("p_drain_empty", p_empty, 1);
        chk("p_peak_within_nbank", (p_peak <= PNB) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
